// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers, used by both the read and write sides of the async FIFO.
// The Gray/binary conversions work on a zero-extended word, so they suit any pointer width up to FIFO_MAX_W.
package fifo_pkg;

  localparam int FIFO_MAX_W = 32;

  typedef logic [FIFO_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return (b >> 1) ^ b;
  endfunction

  // Zero upper bits leave the lower bits unaffected, so one fixed-width loop serves every pointer width.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[FIFO_MAX_W-1] = g[FIFO_MAX_W-1];
    for (int i = FIFO_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_empty_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter for a WIDTH-bit pointer.
module gray2bin #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  fifo_pkg::ptr_word_t bin_wide;

  assign bin_wide = fifo_pkg::gray2bin(fifo_pkg::ptr_word_t'(gray));
  assign bin      = bin_wide[WIDTH-1:0];

endmodule

// File: rtl/rd_empty_ctrl.sv
// Read-side pointer and empty/level flag control for an async FIFO.
// The flags are computed from the next pointer, so a read that drains the FIFO raises empty on the same edge.
module rd_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   syn_wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] rd_ptr_bin;
  logic [PTR_W-1:0] rd_ptr_bin_next;
  logic [PTR_W-1:0] rd_gray_next;
  logic [PTR_W-1:0] wr_bin_s;
  logic [PTR_W-1:0] level_next;
  logic             rd_inc;
  ptr_word_t        gray_wide;

  gray2bin #(.WIDTH(PTR_W)) u_wr_g2b (
    .gray (syn_wr_ptr),
    .bin  (wr_bin_s)
  );

  // A read against an empty FIFO is dropped, not queued; the caller must retry.
  assign rd_inc          = rd_en & ~rd_empty;
  assign rd_ptr_bin_next = rd_ptr_bin + PTR_W'(rd_inc);
  assign gray_wide       = bin2gray(ptr_word_t'(rd_ptr_bin_next));
  assign rd_gray_next    = gray_wide[PTR_W-1:0];

  // The extra MSB keeps the difference correct across wrap: 0..2^ADDR_WIDTH.
  assign level_next = wr_bin_s - rd_ptr_bin_next;

  assign rd_addr = rd_ptr_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge rd_clk) begin
    if (!rd_rstn) begin
      rd_ptr_bin      <= '0;
      rd_ptr          <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_level        <= '0;
      rd_underflow    <= 1'b0;
    end else begin
      rd_ptr_bin      <= rd_ptr_bin_next;
      rd_ptr          <= rd_gray_next;
      rd_empty        <= (rd_gray_next == syn_wr_ptr);
      rd_almost_empty <= (level_next <= PTR_W'(AEMPTY_THRESH));
      rd_level        <= level_next;
      rd_underflow    <= rd_en & rd_empty;
    end
  end

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Scoreboard bench for rd_empty_ctrl at ADDR_WIDTH=3, AEMPTY_THRESH=2 with hand-computed vectors.
module tb_rd_empty_ctrl;

  typedef struct {
    logic [3:0] bin;
    logic       empty;
    logic       ae;
    logic [3:0] level;
    logic       uf;
    string      name;
  } exp_t;

  logic       rd_clk = 1'b0;
  logic       rd_rstn = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] syn_wr_ptr = 4'd0;
  logic [3:0] rd_ptr;
  logic [2:0] rd_addr;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic [3:0] rd_level;
  logic       rd_underflow;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;

  rd_empty_ctrl #(.ADDR_WIDTH(3), .AEMPTY_THRESH(2)) dut (
    .rd_clk          (rd_clk),
    .rd_rstn         (rd_rstn),
    .rd_en           (rd_en),
    .syn_wr_ptr      (syn_wr_ptr),
    .rd_ptr          (rd_ptr),
    .rd_addr         (rd_addr),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the following rising edge.
  task automatic step(input logic rstn, input logic en, input logic [3:0] wg,
                      input logic [3:0] bin, input logic empty, input logic ae,
                      input logic [3:0] lvl, input logic uf, input string nm);
    exp_t x;
    @(negedge rd_clk);
    rd_rstn    = rstn;
    rd_en      = en;
    syn_wr_ptr = wg;
    x.bin = bin; x.empty = empty; x.ae = ae; x.level = lvl; x.uf = uf; x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: every rising edge that has a queued expectation gets checked 1 time unit later.
  always @(posedge rd_clk) begin
    #1;
    if (q.size() > 0) begin
      logic [3:0] g;
      e = q.pop_front();
      g = e.bin ^ (e.bin >> 1);
      chk(e.name, "rd_ptr",   32'(rd_ptr),          32'(g));
      chk(e.name, "rd_addr",  32'(rd_addr),         32'(e.bin[2:0]));
      chk(e.name, "empty",    32'(rd_empty),        32'(e.empty));
      chk(e.name, "a_empty",  32'(rd_almost_empty), 32'(e.ae));
      chk(e.name, "level",    32'(rd_level),        32'(e.level));
      chk(e.name, "underflow",32'(rd_underflow),    32'(e.uf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with rd_en high
    step(0, 1, 4'b0000, 4'd0, 1, 1, 4'd0, 0, "rst0");
    step(0, 1, 4'b0000, 4'd0, 1, 1, 4'd0, 0, "rst1");
    // Fill to 5 then drain
    step(1, 0, 4'b0111, 4'd0, 0, 0, 4'd5, 0, "fill5");
    step(1, 1, 4'b0111, 4'd1, 0, 0, 4'd4, 0, "rd1");
    step(1, 1, 4'b0111, 4'd2, 0, 0, 4'd3, 0, "rd2");
    step(1, 1, 4'b0111, 4'd3, 0, 1, 4'd2, 0, "rd3");
    step(1, 1, 4'b0111, 4'd4, 0, 1, 4'd1, 0, "rd4");
    step(1, 1, 4'b0111, 4'd5, 1, 1, 4'd0, 0, "rd5");
    // Underflow: reads against empty are rejected, pointer holds
    step(1, 1, 4'b0111, 4'd5, 1, 1, 4'd0, 1, "uf1");
    step(1, 1, 4'b0111, 4'd5, 1, 1, 4'd0, 1, "uf2");
    step(1, 1, 4'b0111, 4'd5, 1, 1, 4'd0, 1, "uf3");
    step(1, 0, 4'b0111, 4'd5, 1, 1, 4'd0, 0, "uf_end");
    // Multi-code jump of write pointer to Gray(12), then read across the wrap
    step(1, 0, 4'b1010, 4'd5,  0, 0, 4'd7, 0, "jump12");
    step(1, 1, 4'b1010, 4'd6,  0, 0, 4'd6, 0, "w6");
    step(1, 1, 4'b1010, 4'd7,  0, 0, 4'd5, 0, "w7");
    step(1, 1, 4'b1010, 4'd8,  0, 0, 4'd4, 0, "w8");
    step(1, 1, 4'b1010, 4'd9,  0, 0, 4'd3, 0, "w9");
    step(1, 1, 4'b1010, 4'd10, 0, 1, 4'd2, 0, "w10");
    step(1, 1, 4'b1010, 4'd11, 0, 1, 4'd1, 0, "w11");
    step(1, 1, 4'b1010, 4'd12, 1, 1, 4'd0, 0, "w12");
    step(1, 1, 4'b1010, 4'd12, 1, 1, 4'd0, 1, "w_uf");
    // Full-depth level from zero pointers
    step(0, 0, 4'b1010, 4'd0, 1, 1, 4'd0, 0, "rst_full");
    step(1, 0, 4'b1100, 4'd0, 0, 0, 4'd8, 0, "full8");
    step(1, 1, 4'b1100, 4'd1, 0, 0, 4'd7, 0, "f_rd1");
    step(1, 1, 4'b1100, 4'd2, 0, 0, 4'd6, 0, "f_rd2");
    // Mid-operation reset at level 6, write pointer held at Gray(6)
    step(0, 1, 4'b0101, 4'd0, 1, 1, 4'd0, 0, "rst_mid");
    step(1, 0, 4'b0101, 4'd0, 0, 0, 4'd6, 0, "post_rst");
    step(1, 1, 4'b0101, 4'd1, 0, 0, 4'd5, 0, "post_rd");
    @(posedge rd_clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
